ps2_key_event_fifo: RTL and testbench
=====================================

# ps2_key_event_fifo

Parametrised key-event engine between the PS/2 byte receiver and the display/counter logic. It consumes scan-code bytes through the receiver's ready/nextdata_n handshake and parses make, break and E0-extended sequences. It tracks currently held keys to flag typematic repeats and buffers decoded key events in a first-word-fall-through FIFO for downstream consumers. It also maintains a press counter, a held-key count and a last-pressed code for the seven-segment display path.

## Interface

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
- CNT_W, 8, press counter width.
- HOLD_SLOTS, 4, number of simultaneously tracked held keys (at least 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- rx_data  in  8  byte from PS/2 receiver.
- rx_ready  in  1  receiver has a byte available.
- rx_overflow  in  1  receiver FIFO overflow indicator.
- rx_nextdata_n  out  1  active-low one-cycle byte acknowledge to the receiver.
- ev_data  out  11  head event {brk, rep, ext, code[7:0]}.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer pops head when ev_valid and ev_ready are both high.
- ev_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- ev_lost  out  1  one-cycle pulse: an event was dropped because the FIFO was full.
- proto_err  out  1  one-cycle pulse: illegal byte sequence.
- held_ovf  out  1  one-cycle pulse: a new make arrived while all hold slots were occupied.
- rx_ovf_seen  out  1  sticky; set while rx_overflow=1; cleared only by reset.
- press_cnt  out  CNT_W  count of non-repeat make events; wraps modulo 2^CNT_W.
- held_cnt  out  clog2(HOLD_SLOTS+1)  number of occupied hold slots.
- last_code  out  8  code of the most recent make; becomes 0 when held_cnt returns to 0.

## Operation

- Reset values:
  - Parser: IDLE; FIFO empty; all hold slots invalid.
  - rx_nextdata_n=1; ev_valid=0; ev_count=0.
  - All pulses 0; rx_ovf_seen=0; press_cnt=0; held_cnt=0; last_code=0.
- Byte consumption:
  - A byte is consumed in cycle T when rx_ready=1 and the holdoff counter is 0.
  - On consumption, rx_nextdata_n=0 during T+1 only, and holdoff=2. Holdoff decrements each cycle, so no byte is consumed in T+1 or T+2.
- Parser FSM; every transition happens on a consumed byte:
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - Any other byte emits a make with ext=0 and stays in IDLE.
  - EXT:
    - F0 → EXT_BRK.
    - E0 stays in EXT; no error.
    - Any other byte emits a make with ext=1 → IDLE.
  - BRK: any byte other than E0/F0 emits a break with ext=0 → IDLE.
  - EXT_BRK: any byte other than E0/F0 emits a break with ext=1 → IDLE.
  - E0 or F0 received in BRK or EXT_BRK: proto_err pulse, no event, → IDLE.
- Hold table: each slot holds a valid bit and a 9-bit key {ext, code}. Comparisons use the table contents before the current update.
  - Make, key already held: rep=1. No counter or table change. last_code is updated.
  - Make, key not held: rep=0, press_cnt increments, last_code=code, key is inserted into the lowest-index free slot.
    - If no slot is free: held_ovf pulses and the table is unchanged; the event is still emitted and counted.
  - Break, key held: slot is invalidated. If this was the only held key, last_code=0.
  - Break, key not held: event is emitted with no table change.
- FIFO:
  - Every emitted event is pushed. ev_data shows the head entry.
  - Full with no pop in the same cycle: the event is dropped and ev_lost pulses. Parser and hold-table updates still occur.
  - Full with a pop in the same cycle: the push is accepted and ev_count is unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing

- Byte consumed in cycle T:
  - State, table, counters and FIFO all update at the end of T.
  - During T+1, ev_valid=1 if the FIFO was previously empty.
  - Pulses (ev_lost, proto_err, held_ovf) are high during T+1 only.
- A pop in cycle P presents the next entry in P+1.
- rx_ready held high continuously: bytes are consumed at most once every 3 cycles.
- Asserting rst mid-sequence (for example after E0) discards the prefix, the hold table and the FIFO contents immediately. This takes effect without a clock edge.

## Test plan

- Basic make/break. Bytes 1C, F0, 1C with ev_ready=1:
  - Events 0x01C then 0x41C.
  - press_cnt=1.
  - held_cnt goes 1 then 0.
  - last_code goes 1C then 00.
  - Each byte produces exactly one rx_nextdata_n low cycle.
- Typematic repeat. Bytes 1C, 1C, 1C, F0, 1C:
  - Events 0x01C, 0x21C, 0x21C, 0x41C.
  - press_cnt=1.
- Extended keys. Bytes E0, 75, E0, F0, 75:
  - Events 0x175, 0x575.
  - held_cnt ends at 0.
  - Hold-slot overflow: with HOLD_SLOTS=4, makes 15, 1D, 24, 2D, 2C give held_ovf on the fifth make, press_cnt=5, held_cnt=4.
- FIFO full. ev_ready=0, FIFO_DEPTH=8, nine bytes 1C:
  - ev_count=8 and ev_lost pulses once.
  - Then ev_ready=1: eight pops, with head sequence 0x01C followed by seven 0x21C; ev_valid falls after the 8th pop.
- Protocol error. Bytes F0, E0:
  - proto_err pulse, no event, parser back in IDLE.
  - Next byte 1C gives event 0x01C.
- Reset mid-sequence. Byte E0, then rst pulse, then byte 1C:
  - Event 0x01C (ext=0).
  - All counters restart from 0.

Source files
------------

// File: rtl/ps2_key_event_fifo.sv
// PS/2 key-event engine: parses make/break/E0 scan-code bytes, flags typematic
// repeats against a small held-key table and queues events in a FWFT FIFO.
module ps2_key_event_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8,
    parameter int HOLD_SLOTS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_ready,
    input  logic                              rx_overflow,
    output logic                              rx_nextdata_n,
    output logic [10:0]                       ev_data,
    output logic                              ev_valid,
    input  logic                              ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]       ev_count,
    output logic                              ev_lost,
    output logic                              proto_err,
    output logic                              held_ovf,
    output logic                              rx_ovf_seen,
    output logic [CNT_W-1:0]                  press_cnt,
    output logic [$clog2(HOLD_SLOTS+1)-1:0]   held_cnt,
    output logic [7:0]                        last_code
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_SLOTS + 1);
    localparam int SW = (HOLD_SLOTS > 1) ? $clog2(HOLD_SLOTS) : 1;

    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t state_q, state_d;
    logic [1:0] holdoff_q, holdoff_d;
    logic       nd_q;
    logic       take;

    logic       emit, ev_brk, ev_ext, rep;
    logic       perr_d, perr_q;
    logic       hovf_d, hovf_q;
    logic       lost_d, lost_q;
    logic       ovf_q;

    logic [HOLD_SLOTS-1:0]       vld_q, vld_d;
    logic [HOLD_SLOTS-1:0][8:0]  key_q, key_d;
    logic [8:0]                  key;
    logic                        hit, has_free;
    logic [SW-1:0]               hit_idx, free_idx;
    logic [HW-1:0]               held_c;

    logic [CNT_W-1:0] press_q, press_d;
    logic [7:0]       last_q, last_d;

    logic [10:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, pop, push_ok;
    logic [10:0]   ev_word;

    // Byte acceptance: one byte, then two dead cycles while the receiver advances.
    assign take = rx_ready && (holdoff_q == 2'd0);

    always_comb begin
        holdoff_d = holdoff_q;
        if (take)
            holdoff_d = 2'd2;
        else if (holdoff_q != 2'd0)
            holdoff_d = holdoff_q - 2'd1;
    end

    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev_brk  = 1'b0;
        ev_ext  = 1'b0;
        perr_d  = 1'b0;
        if (take) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == B_EXT)      state_d = S_EXT;
                    else if (rx_data == B_BRK) state_d = S_BRK;
                    else                       emit = 1'b1;
                end
                S_EXT: begin
                    if (rx_data == B_BRK) state_d = S_EXT_BRK;
                    else if (rx_data != B_EXT) begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (rx_data == B_EXT || rx_data == B_BRK) begin
                        perr_d = 1'b1;
                    end else begin
                        emit   = 1'b1;
                        ev_brk = 1'b1;
                        ev_ext = (state_q == S_EXT_BRK);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign key = {ev_ext, rx_data};

    // Descending scan so the lowest-index free slot wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = HOLD_SLOTS - 1; i >= 0; i--) begin
            if (vld_q[i] && key_q[i] == key) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
            if (!vld_q[i]) begin
                has_free = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    always_comb begin
        held_c = '0;
        for (int i = 0; i < HOLD_SLOTS; i++)
            held_c = held_c + HW'(vld_q[i]);
    end

    always_comb begin
        vld_d   = vld_q;
        key_d   = key_q;
        press_d = press_q;
        last_d  = last_q;
        hovf_d  = 1'b0;
        rep     = 1'b0;
        if (emit && !ev_brk) begin
            last_d = rx_data;
            if (hit) begin
                rep = 1'b1;
            end else begin
                press_d = press_q + CNT_W'(1);
                if (has_free) begin
                    vld_d[free_idx] = 1'b1;
                    key_d[free_idx] = key;
                end else begin
                    hovf_d = 1'b1;
                end
            end
        end else if (emit && ev_brk && hit) begin
            vld_d[hit_idx] = 1'b0;
            if (held_c == HW'(1))
                last_d = 8'h00;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign ev_word = {ev_brk, rep, ev_ext, rx_data};
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign pop     = ev_ready && (cnt_q != '0);
    assign push_ok = emit && (!full || pop);
    assign lost_d  = emit && full && !pop;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_q] <= ev_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            holdoff_q <= 2'd0;
            nd_q      <= 1'b1;
            perr_q    <= 1'b0;
            hovf_q    <= 1'b0;
            lost_q    <= 1'b0;
            ovf_q     <= 1'b0;
            vld_q     <= '0;
            key_q     <= '0;
            press_q   <= '0;
            last_q    <= 8'h00;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            holdoff_q <= holdoff_d;
            nd_q      <= !take;
            perr_q    <= perr_d;
            hovf_q    <= hovf_d;
            lost_q    <= lost_d;
            ovf_q     <= ovf_q | rx_overflow;
            vld_q     <= vld_d;
            key_q     <= key_d;
            press_q   <= press_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
        end
    end

    assign rx_nextdata_n = nd_q;
    assign ev_data       = mem_q[rd_q];
    assign ev_valid      = (cnt_q != '0);
    assign ev_count      = cnt_q;
    assign ev_lost       = lost_q;
    assign proto_err     = perr_q;
    assign held_ovf      = hovf_q;
    assign rx_ovf_seen   = ovf_q;
    assign press_cnt     = press_q;
    assign held_cnt      = held_c;
    assign last_code     = last_q;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Bench for ps2_key_event_fifo: scan-code vector table, corner sequences and a
// randomized run against a queue-based reference model checked every cycle.
module tb_ps2_key_event_fifo;
    localparam int FD = 8;
    localparam int HS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic        rx_overflow = 1'b0;
    logic        rx_nextdata_n;
    logic [10:0] ev_data;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic [3:0]  ev_count;
    logic        ev_lost, proto_err, held_ovf, rx_ovf_seen;
    logic [7:0]  press_cnt;
    logic [2:0]  held_cnt;
    logic [7:0]  last_code;

    ps2_key_event_fifo #(.FIFO_DEPTH(FD), .CNT_W(8), .HOLD_SLOTS(HS)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .rx_nextdata_n(rx_nextdata_n),
        .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_count(ev_count), .ev_lost(ev_lost), .proto_err(proto_err),
        .held_ovf(held_ovf), .rx_ovf_seen(rx_ovf_seen), .press_cnt(press_cnt),
        .held_cnt(held_cnt), .last_code(last_code));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int lost_seen = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: prefix flags, a set of held keys, a queue of events.
    logic        m_ext, m_brk;
    int          m_hold;
    logic [8:0]  m_held[$];
    logic [10:0] m_q[$];
    logic [7:0]  m_press, m_last;
    logic        m_seen;
    logic        e_nd, e_lost, e_perr, e_hovf;

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_hold = 0;
        m_held.delete(); m_q.delete();
        m_press = 0; m_last = 0; m_seen = 0;
        e_nd = 1; e_lost = 0; e_perr = 0; e_hovf = 0;
    endfunction

    function automatic void model_step(logic rdy, logic [7:0] b, logic er, logic ovf);
        logic        take, emit, isbrk, found;
        logic [10:0] ev;
        int          idx, pre;
        take = rdy && (m_hold == 0);
        m_hold = take ? 2 : (m_hold > 0 ? m_hold - 1 : 0);
        e_nd = !take; e_lost = 0; e_perr = 0; e_hovf = 0;
        emit = 0; isbrk = 0; ev = '0;
        if (take) begin
            if (m_brk) begin
                if (b == 8'hE0 || b == 8'hF0) e_perr = 1;
                else begin emit = 1; isbrk = 1; ev = {1'b1, 1'b0, m_ext, b}; end
                m_brk = 0; m_ext = 0;
            end else if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin emit = 1; ev = {1'b0, 1'b0, m_ext, b}; m_ext = 0; end
        end
        if (emit) begin
            found = 0; idx = 0;
            foreach (m_held[i]) if (m_held[i] == ev[8:0]) begin found = 1; idx = i; end
            if (!isbrk) begin
                m_last = b;
                if (found) ev[9] = 1'b1;
                else begin
                    m_press = m_press + 8'd1;
                    if (m_held.size() < HS) m_held.push_back(ev[8:0]);
                    else e_hovf = 1;
                end
            end else if (found) begin
                m_held.delete(idx);
                if (m_held.size() == 0) m_last = 0;
            end
        end
        pre = m_q.size();
        if (er && pre > 0) void'(m_q.pop_front());
        if (emit) begin
            if (pre < FD || (er && pre > 0)) m_q.push_back(ev);
            else e_lost = 1;
        end
        if (ovf) m_seen = 1;
    endfunction

    function automatic void cmp_all();
        chk("nextdata_n", 32'(rx_nextdata_n), 32'(e_nd));
        chk("ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
        chk("ev_count", 32'(ev_count), 32'(m_q.size()));
        if (m_q.size() > 0) chk("ev_data", 32'(ev_data), 32'(m_q[0]));
        chk("ev_lost", 32'(ev_lost), 32'(e_lost));
        chk("proto_err", 32'(proto_err), 32'(e_perr));
        chk("held_ovf", 32'(held_ovf), 32'(e_hovf));
        chk("rx_ovf_seen", 32'(rx_ovf_seen), 32'(m_seen));
        chk("press_cnt", 32'(press_cnt), 32'(m_press));
        chk("held_cnt", 32'(held_cnt), 32'(m_held.size()));
        chk("last_code", 32'(last_code), 32'(m_last));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_step(rx_ready, rx_data, ev_ready, rx_overflow);
        if (ev_lost) lost_seen++;
        cmp_all();
    endtask

    // Asynchronous reset, checked with no clock edge in between.
    task automatic do_reset();
        rx_ready = 0; rx_overflow = 0;
        rst = 1;
        #3;
        model_reset();
        cmp_all();
        #2;
        rst = 0;
    endtask

    task automatic send(logic [7:0] b);
        rx_data = b; rx_ready = 1;
        step();
        rx_ready = 0;
        step();
        step();
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        vld;
        logic [10:0] head;
        logic [7:0]  press;
        int          held;
        logic [7:0]  last;
        logic        perr;
        logic        hovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] pick [8];
        int         ph;
        tbl.push_back('{8'h1C, 1, 11'h01C, 8'd1, 1, 8'h1C, 0, 0});
        tbl.push_back('{8'hF0, 0, 11'h000, 8'd1, 1, 8'h1C, 0, 0});
        tbl.push_back('{8'h1C, 1, 11'h41C, 8'd1, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h1C, 1, 11'h01C, 8'd2, 1, 8'h1C, 0, 0});
        tbl.push_back('{8'h1C, 1, 11'h21C, 8'd2, 1, 8'h1C, 0, 0});
        tbl.push_back('{8'h1C, 1, 11'h21C, 8'd2, 1, 8'h1C, 0, 0});
        tbl.push_back('{8'hF0, 0, 11'h000, 8'd2, 1, 8'h1C, 0, 0});
        tbl.push_back('{8'h1C, 1, 11'h41C, 8'd2, 0, 8'h00, 0, 0});
        tbl.push_back('{8'hE0, 0, 11'h000, 8'd2, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h75, 1, 11'h175, 8'd3, 1, 8'h75, 0, 0});
        tbl.push_back('{8'hE0, 0, 11'h000, 8'd3, 1, 8'h75, 0, 0});
        tbl.push_back('{8'hF0, 0, 11'h000, 8'd3, 1, 8'h75, 0, 0});
        tbl.push_back('{8'h75, 1, 11'h575, 8'd3, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h15, 1, 11'h015, 8'd4, 1, 8'h15, 0, 0});
        tbl.push_back('{8'h1D, 1, 11'h01D, 8'd5, 2, 8'h1D, 0, 0});
        tbl.push_back('{8'h24, 1, 11'h024, 8'd6, 3, 8'h24, 0, 0});
        tbl.push_back('{8'h2D, 1, 11'h02D, 8'd7, 4, 8'h2D, 0, 0});
        tbl.push_back('{8'h2C, 1, 11'h02C, 8'd8, 4, 8'h2C, 0, 1});
        tbl.push_back('{8'hF0, 0, 11'h000, 8'd8, 4, 8'h2C, 0, 0});
        tbl.push_back('{8'hE0, 0, 11'h000, 8'd8, 4, 8'h2C, 1, 0});
        tbl.push_back('{8'h1C, 1, 11'h01C, 8'd9, 4, 8'h1C, 0, 1});

        model_reset();
        #2;
        do_reset();

        ev_ready = 1;
        foreach (tbl[i]) begin
            rx_data = tbl[i].data; rx_ready = 1;
            step();
            rx_ready = 0;
            chk("tbl_ack_low", 32'(rx_nextdata_n), 32'd0);
            chk("tbl_valid", 32'(ev_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) chk("tbl_head", 32'(ev_data), 32'(tbl[i].head));
            chk("tbl_press", 32'(press_cnt), 32'(tbl[i].press));
            chk("tbl_held", 32'(held_cnt), 32'(tbl[i].held));
            chk("tbl_last", 32'(last_code), 32'(tbl[i].last));
            chk("tbl_perr", 32'(proto_err), 32'(tbl[i].perr));
            chk("tbl_hovf", 32'(held_ovf), 32'(tbl[i].hovf));
            step();
            chk("tbl_ack_once", 32'(rx_nextdata_n), 32'd1);
            step();
        end

        // FIFO full: nine identical makes with no consumer.
        do_reset();
        ev_ready = 0;
        lost_seen = 0;
        for (int k = 0; k < 9; k++) send(8'h1C);
        chk("full_count", 32'(ev_count), 32'd8);
        chk("full_lost_once", 32'(lost_seen), 32'd1);
        ev_ready = 1;
        for (int k = 0; k < 8; k++) begin
            chk("drain_valid", 32'(ev_valid), 32'd1);
            chk("drain_head", 32'(ev_data), (k == 0) ? 32'h01C : 32'h21C);
            step();
        end
        chk("drain_empty", 32'(ev_valid), 32'd0);

        // Reset in the middle of an E0 prefix.
        do_reset();
        send(8'hE0);
        do_reset();
        ev_ready = 0;
        send(8'h1C);
        chk("rstmid_head", 32'(ev_data), 32'h01C);
        chk("rstmid_press", 32'(press_cnt), 32'd1);
        chk("rstmid_count", 32'(ev_count), 32'd1);

        // Randomized traffic with varying consumer pressure.
        pick = '{8'hE0, 8'hF0, 8'h1C, 8'h1D, 8'h24, 8'h75, 8'h15, 8'h2D};
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            ph = (c / 600) % 3;
            rx_ready    = ($urandom_range(0, 3) != 0);
            rx_data     = pick[$urandom_range(0, 7)];
            ev_ready    = (ph == 0) ? 1'b1 : (ph == 1) ? ($urandom_range(0, 7) == 0)
                                                       : ($urandom_range(0, 1) == 1);
            rx_overflow = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 1999) == 0) do_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
